// File: rtl/coprocessor_controller.sv
// Host-side sequencer for a matrix coprocessor: stages two 5x5 operand matrices,
// issues one command at a time, waits (with timeout) for completion and holds the result.
module coprocessor_controller #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic         wr_sel,
    input  logic [4:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic         start,
    input  logic [2:0]   op_in,
    input  logic [1:0]   size_in,
    input  logic [7:0]   scalar_in,
    input  logic         ack,
    input  logic [4:0]   rd_addr,
    output logic [7:0]   rd_data,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         err,
    output logic [2:0]   cp_op_code,
    output logic [1:0]   cp_matrix_size,
    output logic [7:0]   cp_scalar,
    output logic [199:0] cp_matrix_a,
    output logic [199:0] cp_matrix_b,
    input  logic [199:0] cp_result,
    input  logic         cp_done,
    input  logic         cp_overflow
);

    localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]        OP_INVALID = 3'b111;
    localparam int                N_ELEM     = 25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic               r_err;
    logic [CNT_W-1:0]   r_count;
    logic [2:0]         r_op;
    logic [1:0]         r_size;
    logic [7:0]         r_scalar;
    logic [199:0]       r_result;
    logic [7:0]         r_rd_data;
    logic [7:0]         r_mat_a [N_ELEM];
    logic [7:0]         r_mat_b [N_ELEM];

    logic               w_host_window;
    logic               w_wr_accept;
    logic [7:0]         w_res_elem [32];

    assign w_host_window = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_wr_accept   = wr_en && w_host_window && (wr_addr <= 5'd24);

    // Operand store: a write in the same cycle as start lands before SETUP, so it is executed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_ELEM; i++) begin
                r_mat_a[i] <= '0;
                r_mat_b[i] <= '0;
            end
        end else if (w_wr_accept) begin
            for (int i = 0; i < N_ELEM; i++) begin
                if (wr_addr == 5'(i)) begin
                    if (wr_sel) begin
                        r_mat_b[i] <= wr_data;
                    end else begin
                        r_mat_a[i] <= wr_data;
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_elem
            if (gi < N_ELEM) begin : g_live
                assign cp_matrix_a[8*gi +: 8] = r_mat_a[gi];
                assign cp_matrix_b[8*gi +: 8] = r_mat_b[gi];
                assign w_res_elem[gi]         = r_result[8*gi +: 8];
            end else begin : g_pad
                assign w_res_elem[gi] = 8'd0;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_count  <= '0;
            r_op     <= '0;
            r_size   <= '0;
            r_scalar <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_ovf <= 1'b0;
                        if (op_in == OP_INVALID) begin
                            // Rejected opcode never reaches the coprocessor; previous command registers stay.
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_op     <= op_in;
                            r_size   <= size_in;
                            r_scalar <= scalar_in;
                            r_err    <= 1'b0;
                            r_state  <= S_SETUP;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                        end
                    end else if ((r_state == S_DONE) && ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_count <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cp_done) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == CNT_LAST) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_ovf    <= 1'b0;
                            r_result <= '0;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_result <= cp_result;
                    r_ovf    <= cp_overflow;
                    r_err    <= 1'b0;
                    r_state  <= S_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_res_elem[rd_addr];
        end
    end

    assign rd_data        = r_rd_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign ovf            = r_ovf;
    assign err            = r_err;
    assign cp_op_code     = r_op;
    assign cp_matrix_size = r_size;
    assign cp_scalar      = r_scalar;

endmodule
